// File: rtl/sram2k8_arbiter_if.sv
// rtl/sram2k8_arbiter_if.sv - video/CPU request ports and SRAM2k8 pin bundle for sram2k8_arbiter
interface sram2k8_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_dout;
  logic          vid_valid;
  logic          vid_ovr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wr_n;
  logic          ram_rd_n;
  logic [DW-1:0] ram_dout;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  vid_dout, vid_valid, vid_ovr, cpu_dout, cpu_ack, busy,
           ram_addr, ram_din, ram_wr_n, ram_rd_n
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output vid_dout, vid_valid, vid_ovr, cpu_dout, cpu_ack, busy,
           ram_addr, ram_din, ram_wr_n, ram_rd_n
  );
endinterface

// File: rtl/sram2k8_arbiter.sv
// rtl/sram2k8_arbiter.sv - shares one SRAM2k8 between a strict-priority video read port and a CPU req/ack port
module sram2k8_arbiter #(
  parameter int AW = 11
) (
  input logic              clk,
  input logic              rst_n,
  sram2k8_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_ACC = 2'd1;
  localparam logic [1:0] RD_CAP = 2'd2;
  localparam logic [1:0] WR_ACC = 2'd3;

  logic [1:0]    state;
  logic          vp;
  logic [AW-1:0] vp_addr;
  logic          owner_vid;
  logic          issue_vid;
  logic          take_vid;

  // A strobe landing on the edge that issues the pending read refills vp instead of overrunning
  assign issue_vid = (state == IDLE) && vp;
  assign take_vid  = bus.vid_req && (!vp || issue_vid);
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp      <= 1'b0;
      vp_addr <= '0;
      bus.vid_ovr <= 1'b0;
    end else begin
      if (take_vid) begin
        vp      <= 1'b1;
        vp_addr <= bus.vid_addr;
      end else if (issue_vid) begin
        vp <= 1'b0;
      end
      if (bus.vid_req && !take_vid) begin
        bus.vid_ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner_vid     <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_din   <= '0;
      bus.ram_wr_n  <= 1'b1;
      bus.ram_rd_n  <= 1'b1;
      bus.vid_dout  <= '0;
      bus.vid_valid <= 1'b0;
      bus.cpu_dout  <= '0;
      bus.cpu_ack   <= 1'b0;
    end else begin
      bus.vid_valid <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (vp) begin
            bus.ram_addr <= vp_addr;
            bus.ram_rd_n <= 1'b0;
            owner_vid    <= 1'b1;
            state        <= RD_ACC;
          end else if (bus.cpu_req && !bus.cpu_we) begin
            bus.ram_addr <= bus.cpu_addr;
            bus.ram_rd_n <= 1'b0;
            owner_vid    <= 1'b0;
            state        <= RD_ACC;
          end else if (bus.cpu_req && bus.cpu_we) begin
            bus.ram_addr <= bus.cpu_addr;
            bus.ram_din  <= bus.cpu_din;
            bus.ram_wr_n <= 1'b0;
            state        <= WR_ACC;
          end
        end
        RD_ACC: begin
          bus.ram_rd_n <= 1'b1;
          state        <= RD_CAP;
        end
        RD_CAP: begin
          // SRAM output is registered, so data appears one edge after RD_n was sampled
          if (owner_vid) begin
            bus.vid_dout  <= bus.ram_dout;
            bus.vid_valid <= 1'b1;
          end else begin
            bus.cpu_dout <= bus.ram_dout;
            bus.cpu_ack  <= 1'b1;
          end
          state <= IDLE;
        end
        WR_ACC: begin
          bus.ram_wr_n <= 1'b1;
          bus.cpu_ack  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram2k8_arbiter.sv
// tb/tb_sram2k8_arbiter.sv - directed and random-traffic bench for sram2k8_arbiter with an SRAM2k8 model
module tb_sram2k8_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram2k8_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sram2k8_arbiter #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];

  // registered synchronous SRAM2k8
  always @(posedge clk) begin
    if (!bus.ram_wr_n) mem[bus.ram_addr] <= bus.ram_din;
    if (!bus.ram_rd_n) bus.ram_dout <= mem[bus.ram_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [10:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] q, output int wr_lo);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
    lat = 0; wr_lo = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.ram_wr_n) wr_lo++;
    end while (!bus.cpu_ack && lat < 40);
    q = bus.cpu_dout;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic vid_rd(input logic [10:0] a, output int lat, output logic [7:0] q);
    bus.vid_req = 1'b1; bus.vid_addr = a; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.vid_req = 1'b0;
    end while (!bus.vid_valid && lat < 40);
    q = bus.vid_dout;
  endtask

  task automatic vid_burst(input int gap, input logic [10:0] a0, input logic [10:0] a1,
                           output int t0, output int t1, output logic [7:0] q0, output logic [7:0] q1);
    int nv;
    nv = 0; t0 = 0; t1 = 0; q0 = 0; q1 = 0;
    bus.vid_req = 1'b1; bus.vid_addr = a0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      bus.vid_req = 1'b0;
      if (n == gap) begin bus.vid_req = 1'b1; bus.vid_addr = a1; end
      if (bus.vid_valid) begin
        if (nv == 0) begin t0 = n; q0 = bus.vid_dout; end
        else begin t1 = n; q1 = bus.vid_dout; end
        nv++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wl, t0, t1, ta, tv, nv, cnt;
    logic [7:0] q, q0, q1, cq, vq;

    bus.vid_req = 0; bus.vid_addr = 0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_din = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h96;
    mem[11'h123] = 8'hC3;
    mem[11'h0AA] = 8'h11; mem[11'h0BB] = 8'h22;
    mem[11'h044] = 8'h77; mem[11'h055] = 8'h55;

    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.ram_rd_n, bus.ram_wr_n, bus.busy, bus.vid_valid, bus.cpu_ack, bus.vid_ovr}, 6'b110000);
    check("rst_addr_din", {bus.ram_addr, bus.ram_din}, 0);
    check("rst_douts", {bus.vid_dout, bus.cpu_dout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while the video read sits in RD_ACC
    bus.vid_req = 1'b1; bus.vid_addr = 11'h123;
    @(negedge clk);
    bus.vid_req = 1'b0;
    @(negedge clk);
    check("pre_rst_rd_acc", {bus.ram_rd_n, bus.busy}, 2'b01);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {bus.ram_rd_n, bus.ram_wr_n, bus.busy, bus.vid_valid, bus.cpu_ack}, 5'b11000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.vid_valid || !bus.ram_rd_n) cnt++;
    end
    check("rst_read_discarded", cnt, 0);

    cpu_op(1'b1, 11'h7FF, 8'h5A, lat, q, wl);
    check("wr_7ff_lat", lat, 2);
    check("wr_7ff_wr_n_width", wl, 1);
    cpu_op(1'b0, 11'h7FF, 8'h00, lat, q, wl);
    check("rd_7ff_lat", lat, 3);
    check("rd_7ff_data", q, 8'h5A);

    vid_rd(11'h123, lat, q);
    check("vid_123_lat", lat, 4);
    check("vid_123_data", q, 8'hC3);

    // CPU read and a second video strobe arrive together while video is pending
    bus.vid_req = 1'b1; bus.vid_addr = 11'h0AA;
    @(negedge clk);
    bus.vid_addr = 11'h0BB;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h7FF;
    t0 = 0; t1 = 0; ta = 0; nv = 0; q0 = 0; q1 = 0; cq = 0;
    for (int n = 1; n <= 40 && ta == 0; n++) begin
      @(negedge clk);
      bus.vid_req = 1'b0;
      if (bus.vid_valid) begin
        if (nv == 0) begin t0 = n; q0 = bus.vid_dout; end else begin t1 = n; q1 = bus.vid_dout; end
        nv++;
      end
      if (bus.cpu_ack) begin ta = n; cq = bus.cpu_dout; bus.cpu_req = 1'b0; end
    end
    check("prio_vid_a", {t0[7:0], q0}, {8'd3, 8'h11});
    check("prio_vid_b", {t1[7:0], q1}, {8'd6, 8'h22});
    check("prio_cpu_after_vid", {ta[7:0], cq}, {8'd9, 8'h5A});
    check("prio_no_ovr", bus.vid_ovr, 1'b0);

    // strobes 2 apart while the RAM is busy with a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h123;
    bus.vid_req = 1'b1; bus.vid_addr = 11'h044;
    ta = 0; tv = 0; nv = 0; cq = 0; vq = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      bus.vid_req = 1'b0;
      if (n == 2) begin bus.vid_req = 1'b1; bus.vid_addr = 11'h055; end
      if (bus.cpu_ack) begin ta = n; cq = bus.cpu_dout; bus.cpu_req = 1'b0; end
      if (bus.vid_valid) begin nv++; tv = n; vq = bus.vid_dout; end
    end
    check("ovr_cpu", {ta[7:0], cq}, {8'd3, 8'hC3});
    check("ovr_first_data", {tv[7:0], vq}, {8'd6, 8'h77});
    check("ovr_second_dropped", nv, 1);
    check("ovr_sticky", bus.vid_ovr, 1'b1);

    do_reset();
    check("ovr_cleared_by_reset", bus.vid_ovr, 1'b0);

    vid_burst(4, 11'h044, 11'h0AA, t0, t1, q0, q1);
    check("gap4_times", {t0[7:0], t1[7:0]}, {8'd4, 8'd8});
    check("gap4_data", {q0, q1}, {8'h77, 8'h11});
    check("gap4_no_ovr", bus.vid_ovr, 1'b0);
    vid_burst(1, 11'h0BB, 11'h123, t0, t1, q0, q1);
    check("issue_edge_times", {t0[7:0], t1[7:0]}, {8'd4, 8'd7});
    check("issue_edge_data", {q0, q1}, {8'h22, 8'hC3});
    check("issue_edge_no_ovr", bus.vid_ovr, 1'b0);

    cpu_op(1'b1, 11'h000, 8'h33, lat, q, wl);
    cpu_op(1'b1, 11'h7FF, 8'hCC, lat, q, wl);
    cpu_op(1'b0, 11'h000, 8'h00, lat, q0, wl);
    cpu_op(1'b0, 11'h7FF, 8'h00, lat, q1, wl);
    check("wrap_data", {q0, q1}, {8'h33, 8'hCC});

    begin : random_run
      int vgap, cgap, cpu_err, vid_err, overlap, widerr, acks, vals;
      logic rd_prev, wr_prev;
      logic [10:0] ca, va;
      logic [7:0] cd;
      logic [10:0] vfifo [$];
      for (int i = 0; i < 2048; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
      vgap = 3; cgap = 0; cpu_err = 0; vid_err = 0; overlap = 0; widerr = 0; acks = 0; vals = 0;
      rd_prev = 1'b1; wr_prev = 1'b1; ca = 0; cd = 0;
      for (int c = 0; c < 10000; c++) begin
        @(negedge clk);
        bus.vid_req = 1'b0;
        if (!bus.ram_rd_n && !bus.ram_wr_n) overlap++;
        if ((!bus.ram_rd_n && !rd_prev) || (!bus.ram_wr_n && !wr_prev)) widerr++;
        rd_prev = bus.ram_rd_n; wr_prev = bus.ram_wr_n;
        if (bus.cpu_ack) begin
          acks++;
          if (bus.cpu_we) ref_mem[ca] = cd;
          else if (bus.cpu_dout !== ref_mem[ca]) cpu_err++;
          bus.cpu_req = 1'b0;
          cgap = $urandom_range(0, 3);
        end else if (!bus.cpu_req && c < 9950) begin
          if (cgap == 0) begin
            ca = 11'($urandom); cd = 8'($urandom);
            bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_addr = ca; bus.cpu_din = cd;
            bus.cpu_req = 1'b1;
          end else cgap--;
        end
        if (bus.vid_valid) begin
          vals++;
          if (vfifo.size() == 0) vid_err++;
          else begin
            if (bus.vid_dout !== ref_mem[vfifo[0]]) vid_err++;
            void'(vfifo.pop_front());
          end
        end
        if (vgap == 0 && c < 9950) begin
          va = 11'($urandom);
          bus.vid_req = 1'b1; bus.vid_addr = va;
          vfifo.push_back(va);
          vgap = $urandom_range(8, 15);
        end else if (vgap > 0) vgap--;
      end
      check("rand_cpu_data", cpu_err, 0);
      check("rand_vid_data", vid_err, 0);
      check("rand_rd_wr_overlap", overlap, 0);
      check("rand_strobe_width", widerr, 0);
      check("rand_no_ovr", bus.vid_ovr, 1'b0);
      check("rand_drained", {vfifo.size(), 31'(bus.cpu_req)}, 0);
      check("rand_activity", (acks > 500 && vals > 500), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
